// File: rtl/gpio_key_conditioner.sv
// GPIO input conditioner: 2-flop synchroniser on every bit, a debounce stage on the
// low NUM_KEYS bits, and press/release events queued in a small FWFT FIFO.
module gpio_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic sync_bit,
    output logic level,
    output logic edge_pulse
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt;

    // Any return to the stable level restarts the count, so short glitches never commit.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt        <= '0;
            level      <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            edge_pulse <= 1'b0;
            if (sync_bit == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level      <= sync_bit;
                cnt        <= '0;
                edge_pulse <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module gpio_key_conditioner #(
    parameter int GPIO_WIDTH      = 32,
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH       = 20,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [GPIO_WIDTH-1:0] gpio_in_raw,
    output logic [GPIO_WIDTH-1:0] gpio_in_clean,
    output logic [NUM_KEYS-1:0]   key_level,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [7:0]            evt_data,
    output logic                  evt_irq,
    output logic                  evt_overflow,
    input  logic                  clr_overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    logic [GPIO_WIDTH-1:0] sync1, sync2;
    logic [NUM_KEYS-1:0]   edge_q, pend, ptype, grant;
    logic [6:0]            sel_idx;
    logic                  sel_type, push, pop, full;
    logic [7:0]            mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [PW:0]           count;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in_raw;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        gpio_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_deb (
            .gclk      (axi_aclk),
            .grst_n    (axi_aresetn),
            .sync_bit  (sync2[g]),
            .level     (key_level[g]),
            .edge_pulse(edge_q[g])
        );
    end

    for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_clean
        if (g < NUM_KEYS) begin : g_deb
            assign gpio_in_clean[g] = key_level[g];
        end else begin : g_pass
            assign gpio_in_clean[g] = sync2[g];
        end
    end

    // Fixed priority: descending scan so the lowest pending index is the last write.
    always_comb begin
        grant    = '0;
        sel_idx  = '0;
        sel_type = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                sel_idx  = 7'(i);
                sel_type = ptype[i];
            end
        end
        push = (|pend) && !full;
        if (!push) grant = '0;
    end

    // A new edge on a key whose previous event was not taken this cycle loses that event.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pend         <= '0;
            ptype        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (edge_q[k]) begin
                    pend[k]  <= 1'b1;
                    ptype[k] <= key_level[k];
                end else if (grant[k]) begin
                    pend[k] <= 1'b0;
                end
            end
            if (|(edge_q & pend & ~grant)) evt_overflow <= 1'b1;
            else if (clr_overflow)         evt_overflow <= 1'b0;
        end
    end

    assign full      = (count == FULL_CNT);
    assign evt_valid = (count != '0);
    assign evt_irq   = evt_valid;
    assign pop       = evt_valid && evt_ready;
    assign evt_data  = evt_valid ? mem[rptr] : 8'h00;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= {sel_type, sel_idx};
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_gpio_key_conditioner.sv
// Directed bench for gpio_key_conditioner with DEBOUNCE_CYCLES=16, FIFO_DEPTH=4.
module tb_gpio_key_conditioner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] raw;
    logic [31:0] clean;
    logic [3:0]  key_level;
    logic        evt_valid, evt_ready, evt_irq, evt_overflow, clr_overflow;
    logic [7:0]  evt_data;
    int          checks = 0;
    int          failures = 0;

    gpio_key_conditioner #(
        .GPIO_WIDTH(32), .NUM_KEYS(4), .DEBOUNCE_CYCLES(16), .CNT_WIDTH(5), .FIFO_DEPTH(4)
    ) dut (
        .axi_aclk     (clk),
        .axi_aresetn  (rst_n),
        .gpio_in_raw  (raw),
        .gpio_in_clean(clean),
        .key_level    (key_level),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .evt_irq      (evt_irq),
        .evt_overflow (evt_overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; raw = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("rst_clean", clean, 32'h0);
        chk("rst_level", 32'(key_level), 32'h0);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_data", 32'(evt_data), 32'h0);
        chk("rst_ovf", 32'(evt_overflow), 32'h0);
        chk("rst_irq", 32'(evt_irq), 32'h0);

        // Key 0 press: level after exactly 18 edges, event 2 cycles later
        raw[0] = 1'b1;
        tick(17);
        chk("k0_lvl_early", 32'(key_level), 32'h0);
        tick(1);
        chk("k0_lvl", 32'(key_level), 32'h1);
        chk("k0_clean", clean, 32'h1);
        tick(1);
        chk("k0_valid_early", 32'(evt_valid), 32'h0);
        tick(1);
        chk("k0_valid", 32'(evt_valid), 32'h1);
        chk("k0_irq", 32'(evt_irq), 32'h1);
        chk("k0_press", 32'(evt_data), 32'h80);
        tick(20);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("k0_popped", 32'(evt_valid), 32'h0);
        raw[0] = 1'b0;
        tick(18);
        chk("k0_rel_lvl", 32'(key_level), 32'h0);
        tick(2);
        chk("k0_rel_valid", 32'(evt_valid), 32'h1);
        chk("k0_release", 32'(evt_data), 32'h00);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;

        // Bounce rejection on key 1
        for (int p = 0; p < 5; p++) begin
            raw[1] = 1'b1;
            tick(15);
            raw[1] = 1'b0;
            tick(5);
        end
        tick(20);
        chk("bounce_lvl", 32'(key_level), 32'h0);
        chk("bounce_valid", 32'(evt_valid), 32'h0);
        raw[1] = 1'b1;
        tick(16);
        raw[1] = 1'b0;
        tick(2);
        chk("pulse16_lvl", 32'(key_level), 32'h2);
        tick(2);
        chk("pulse16_press", 32'(evt_data), 32'h81);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        tick(19);
        chk("pulse16_rel_valid", 32'(evt_valid), 32'h1);
        chk("pulse16_release", 32'(evt_data), 32'h01);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("pulse16_empty", 32'(evt_valid), 32'h0);

        // Simultaneous keys drain lowest index first
        raw[3:0] = 4'hF;
        evt_ready = 1'b1;
        tick(20);
        chk("sim_ev0", 32'(evt_data), 32'h80);
        tick(1);
        chk("sim_ev1", 32'(evt_data), 32'h81);
        tick(1);
        chk("sim_ev2", 32'(evt_data), 32'h82);
        tick(1);
        chk("sim_ev3", 32'(evt_data), 32'h83);
        tick(1);
        chk("sim_empty", 32'(evt_valid), 32'h0);
        raw[3:0] = 4'h0;
        tick(25);
        chk("sim_rel_empty", 32'(evt_valid), 32'h0);
        chk("sim_rel_lvl", 32'(key_level), 32'h0);
        chk("sim_no_ovf", 32'(evt_overflow), 32'h0);

        // Overflow: six edges on key 2 with no consumer
        evt_ready = 1'b0;
        for (int e = 0; e < 6; e++) begin
            raw[2] = ~raw[2];
            tick(20);
        end
        chk("ovf_set", 32'(evt_overflow), 32'h1);
        chk("ovf_head", 32'(evt_data), 32'h82);
        evt_ready = 1'b1;
        tick(1);
        chk("drain1", 32'(evt_data), 32'h02);
        tick(1);
        chk("drain2", 32'(evt_data), 32'h82);
        tick(1);
        chk("drain3", 32'(evt_data), 32'h02);
        tick(1);
        chk("drain4_pend", 32'(evt_data), 32'h02);
        chk("drain4_valid", 32'(evt_valid), 32'h1);
        tick(1);
        chk("drain_empty", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;
        chk("ovf_sticky", 32'(evt_overflow), 32'h1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("ovf_clr", 32'(evt_overflow), 32'h0);

        // Passthrough bit 31
        raw[31] = 1'b1;
        tick(1);
        chk("pass_early", 32'(clean[31]), 32'h0);
        tick(1);
        chk("pass", 32'(clean[31]), 32'h1);
        tick(20);
        chk("pass_no_evt", 32'(evt_valid), 32'h0);

        // Reset mid-debounce with a queued event
        raw[3] = 1'b1;
        tick(20);
        chk("pre_rst_evt", 32'(evt_data), 32'h83);
        raw[0] = 1'b1;
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_valid), 32'h0);
        chk("mid_rst_lvl", 32'(key_level), 32'h0);
        chk("mid_rst_clean", clean, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(17);
        chk("post_rst_early", 32'(key_level), 32'h0);
        tick(1);
        chk("post_rst_lvl", 32'(key_level), 32'h9);
        chk("post_rst_clean", clean, 32'h8000_0009);
        tick(2);
        chk("post_rst_evt", 32'(evt_data), 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
